// File: rtl/col_output_ctrl_pkg.sv
// Shared constants and row-buffer types for the systolic-array output collector.
package col_output_ctrl_pkg;

  localparam int NCOL  = 8;
  localparam int DW    = 8;
  localparam int OW    = 32;
  localparam int WPR   = NCOL * DW / OW;
  localparam int DEPTH = 8;
  localparam int BPW   = OW / DW;

  typedef logic [DW-1:0] col_byte_t;
  typedef logic [NCOL-1:0][DW-1:0] row_buf_t;

  // Word idx of a row holds columns idx*BPW upward, lowest column in the low byte.
  function automatic logic [OW-1:0] pack_word(input row_buf_t row, input int idx);
    logic [OW-1:0] w;
    w = '0;
    for (int b = 0; b < BPW; b++) begin
      w[b*DW +: DW] = row[idx*BPW + b];
    end
    return w;
  endfunction

endpackage

// File: rtl/col_output_ctrl_out_word_fifo.sv
// Output word FIFO: two words written per push (word0 lands first), one word popped per read.
module out_word_fifo #(
  parameter int DEPTH = 8,
  parameter int OW    = 32
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push,
  input  logic [OW-1:0]              wdata0,
  input  logic [OW-1:0]              wdata1,
  input  logic                       pop,
  output logic [OW-1:0]              head,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [OW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_pop;

  assign do_pop = pop && (count != '0);
  assign head   = (count != '0) ? mem[rd_ptr] : '0;

  // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr]             <= wdata0;
        mem[wr_ptr + AW'(1)]    <= wdata1;
        wr_ptr                  <= wr_ptr + AW'(2);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + (push ? CW'(2) : CW'(0)) - (do_pop ? CW'(1) : CW'(0));
    end
  end

endmodule

// File: rtl/col_output_ctrl.sv
// Collects one skewed byte per array column into a row buffer and ships full rows
// as two packed words into the output FIFO.
module col_output_ctrl
  import col_output_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic [DW-1:0]     in_r [NCOL],
  input  logic [0:NCOL-1]   in_v,
  input  logic              rread,
  output logic [OW-1:0]     out_r,
  output logic              rvalid
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [NCOL-1:0] got;
  row_buf_t        rowbuf;
  logic            row_full;
  logic            push;
  logic            pop;
  logic [CW-1:0]   fifo_count;

  assign row_full = &got;
  // Free space is judged on the registered count; a pop in the same cycle does not help.
  assign push     = row_full && (fifo_count <= CW'(DEPTH - WPR));
  assign pop      = rread && rvalid;
  assign rvalid   = (fifo_count != '0);

  // On a push edge the old row leaves and any arriving byte starts the next row.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      got    <= '0;
      rowbuf <= '0;
    end else begin
      for (int k = 0; k < NCOL; k++) begin
        if (push) begin
          got[k] <= in_v[k];
        end else if (in_v[k]) begin
          got[k] <= 1'b1;
        end
        if (in_v[k] && (push || !got[k])) begin
          rowbuf[k] <= in_r[k];
        end
      end
    end
  end

  out_word_fifo #(
    .DEPTH (DEPTH),
    .OW    (OW)
  ) u_fifo (
    .clk    (clk),
    .rstn   (rstn),
    .push   (push),
    .wdata0 (pack_word(rowbuf, 0)),
    .wdata1 (pack_word(rowbuf, 1)),
    .pop    (pop),
    .head   (out_r),
    .count  (fifo_count)
  );

endmodule

// File: tb/tb_col_output_ctrl.sv
// Directed self-checking bench for col_output_ctrl.
module tb_col_output_ctrl;
  import col_output_ctrl_pkg::*;

  logic            clk;
  logic            rstn;
  logic [DW-1:0]   in_r [NCOL];
  logic [0:NCOL-1] in_v;
  logic            rread;
  logic [OW-1:0]   out_r;
  logic            rvalid;

  int n_cmp;
  int n_bad;

  col_output_ctrl dut (
    .clk    (clk),
    .rstn   (rstn),
    .in_r   (in_r),
    .in_v   (in_v),
    .rread  (rread),
    .out_r  (out_r),
    .rvalid (rvalid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [0:NCOL-1] colmask(input int lo, input int hi);
    logic [0:NCOL-1] m;
    m = '0;
    for (int k = lo; k <= hi; k++) m[k] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] mkword(input logic [7:0] b);
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  task automatic setBytes(input logic [7:0] base);
    for (int k = 0; k < NCOL; k++) in_r[k] = base + 8'(k);
  endtask

  task automatic applyStimulus(input logic [0:NCOL-1] v, input logic rd);
    in_v  = v;
    rread = rd;
    @(posedge clk);
    #1;
    in_v  = '0;
    rread = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic exp_v, input logic [31:0] exp_d);
    n_cmp++;
    assert (rvalid === exp_v) else begin
      n_bad++;
      $error("[TB] FAIL %s rvalid: got %0b expected %0b", tag, rvalid, exp_v);
    end
    n_cmp++;
    assert (out_r === exp_d) else begin
      n_bad++;
      $error("[TB] FAIL %s out_r: got %h expected %h", tag, out_r, exp_d);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rstn  = 1'b0;
    in_v  = '0;
    rread = 1'b1;
    setBytes(8'h00);

    #3;
    checkOutput("reset", 1'b0, 32'h0);
    #9;
    rstn = 1'b1;
    applyStimulus('0, 1'b1);
    applyStimulus('0, 1'b1);
    checkOutput("read_empty_at_exit", 1'b0, 32'h0);

    $display("[TB] single-cycle row");
    setBytes(8'h01);
    applyStimulus(colmask(0, NCOL-1), 1'b0);
    checkOutput("single_early", 1'b0, 32'h0);
    applyStimulus('0, 1'b0);
    checkOutput("single_w0", 1'b1, 32'h04030201);
    applyStimulus('0, 1'b1);
    checkOutput("single_w1", 1'b1, 32'h08070605);
    applyStimulus('0, 1'b1);
    checkOutput("single_empty", 1'b0, 32'h0);

    $display("[TB] skewed row");
    setBytes(8'h10);
    for (int k = 0; k < NCOL; k++) begin
      applyStimulus(colmask(k, k), 1'b0);
      checkOutput($sformatf("skew_early%0d", k), 1'b0, 32'h0);
    end
    applyStimulus('0, 1'b0);
    checkOutput("skew_w0", 1'b1, 32'h13121110);
    applyStimulus('0, 1'b1);
    checkOutput("skew_w1", 1'b1, 32'h17161514);
    applyStimulus('0, 1'b1);
    checkOutput("skew_empty", 1'b0, 32'h0);

    $display("[TB] duplicate byte");
    setBytes(8'h20);
    in_r[2] = 8'hAA;
    applyStimulus(colmask(0, 2), 1'b0);
    in_r[2] = 8'hBB;
    applyStimulus(colmask(2, 2), 1'b0);
    checkOutput("dup_early", 1'b0, 32'h0);
    applyStimulus(colmask(3, NCOL-1), 1'b0);
    applyStimulus('0, 1'b0);
    checkOutput("dup_w0", 1'b1, 32'h23AA2120);
    applyStimulus('0, 1'b1);
    checkOutput("dup_w1", 1'b1, 32'h27262524);
    applyStimulus('0, 1'b1);
    checkOutput("dup_empty", 1'b0, 32'h0);

    $display("[TB] fifo full with held row");
    for (int r = 0; r < 5; r++) begin
      setBytes(8'h40 + 8'(8 * r));
      applyStimulus(colmask(0, NCOL-1), 1'b0);
    end
    setBytes(8'hEE);
    applyStimulus(colmask(0, 0), 1'b0);
    checkOutput("full_head", 1'b1, 32'h43424140);
    for (int w = 0; w < 10; w++) begin
      checkOutput($sformatf("full_drain%0d", w), 1'b1, mkword(8'h40 + 8'(4 * w)));
      applyStimulus('0, 1'b1);
    end
    checkOutput("full_empty", 1'b0, 32'h0);

    $display("[TB] push during pop");
    setBytes(8'h80);
    applyStimulus(colmask(0, NCOL-1), 1'b0);
    applyStimulus('0, 1'b0);
    checkOutput("pp_first", 1'b1, 32'h83828180);
    setBytes(8'h90);
    applyStimulus(colmask(0, NCOL-1), 1'b0);
    applyStimulus('0, 1'b1);
    checkOutput("pp_after_both", 1'b1, 32'h87868584);
    applyStimulus('0, 1'b1);
    checkOutput("pp_w2", 1'b1, 32'h93929190);
    applyStimulus('0, 1'b1);
    checkOutput("pp_w3", 1'b1, 32'h97969594);
    applyStimulus('0, 1'b1);
    checkOutput("pp_empty", 1'b0, 32'h0);

    $display("[TB] reset mid-operation");
    setBytes(8'hA0);
    applyStimulus(colmask(0, NCOL-1), 1'b0);
    applyStimulus('0, 1'b0);
    setBytes(8'hB0);
    applyStimulus(colmask(0, 2), 1'b0);
    checkOutput("mid_stored", 1'b1, 32'hA3A2A1A0);
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("mid_reset", 1'b0, 32'h0);
    #2;
    rstn = 1'b1;
    setBytes(8'hC0);
    applyStimulus(colmask(3, NCOL-1), 1'b0);
    applyStimulus('0, 1'b0);
    checkOutput("mid_partial_cleared", 1'b0, 32'h0);
    applyStimulus(colmask(0, 2), 1'b0);
    applyStimulus('0, 1'b0);
    checkOutput("mid_w0", 1'b1, 32'hC3C2C1C0);
    applyStimulus('0, 1'b1);
    checkOutput("mid_w1", 1'b1, 32'hC7C6C5C4);
    applyStimulus('0, 1'b1);
    checkOutput("mid_empty", 1'b0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
